// File: rtl/bsg_idiv_iterative_fast.sv
// ---------------------------------------------------------------------------
// bsg_idiv_iterative_fast
//
// Iterative restoring integer divider, signed or unsigned, retiring
// bits_per_iter_p (1, 2 or 4) quotient bits per cycle. With early_out_p set,
// iterations start at the most significant set bit of |dividend|, so small
// dividends finish early. Divide-by-zero and zero-dividend requests skip the
// iteration phase entirely.
//
// Request side uses valid/ready-and, response side uses valid/yumi. Only one
// request is in flight at a time; the block is idle again the cycle after
// the result is taken.
//
// Parameters:
//   width_p          operand width (>= 4, divisible by bits_per_iter_p)
//   bits_per_iter_p  quotient bits per iteration: 1, 2 or 4
//   early_out_p      1: skip leading-zero iterations of |dividend|
//
// Ports:
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   v_i            request valid
//   ready_and_o    idle, able to accept a request
//   dividend_i     dividend
//   divisor_i      divisor
//   signed_div_i   1: two's-complement signed, 0: unsigned
//   v_o            result valid
//   quotient_o     quotient (registered, stable while v_o is high)
//   remainder_o    remainder (registered, stable while v_o is high)
//   yumi_i         consumer takes the result (only while v_o is high)
//
// Optional feature (macro BSG_IDIV_ITERATIVE_FAST_RESULT_CACHE_EN):
//   When defined, the last completed {dividend, divisor, signed} triple and
//   its results are kept. A request matching the valid entry goes straight
//   from idle to done, so v_o rises in the cycle after acceptance. This
//   serves quotient/remainder instruction pairs on the same operands.
//   When undefined there is no cache storage and every request takes the
//   full path.
// ---------------------------------------------------------------------------
module bsg_idiv_iterative_fast #(
  parameter int width_p         = 32,
  parameter int bits_per_iter_p = 1,
  parameter int early_out_p     = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_and_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_div_i,
  output logic               v_o,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  input  logic               yumi_i
);

  // Counter width large enough to hold the value width_p itself.
  localparam int CW    = $clog2(width_p + 1);
  localparam int LOG_B = $clog2(bits_per_iter_p);

  localparam logic [CW-1:0] WIDTH_C      = CW'(width_p);
  localparam logic [CW-1:0] FULL_ITERS_C = CW'(width_p / bits_per_iter_p);
  localparam logic [CW:0]   ROUND_C      = (CW+1)'(bits_per_iter_p - 1);

  typedef enum logic [2:0] {
    eIDLE,
    eCALC,
    eDIV,
    eFIX,
    eDONE
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Latched request
  logic [width_p-1:0] r_dividend;
  logic [width_p-1:0] r_divisor;
  logic               r_signed;

  // Iteration datapath
  logic [width_p-1:0] r_divisor_abs;
  logic [width_p-1:0] r_rem;
  logic [width_p-1:0] r_quo;
  logic [CW-1:0]      r_iter;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div_zero;

  // Registered results
  logic [width_p-1:0] r_quotient;
  logic [width_p-1:0] r_remainder;

  logic               w_accept;
  logic               w_cache_hit;
  logic [width_p-1:0] w_cache_quotient;
  logic [width_p-1:0] w_cache_remainder;

  logic               w_dividend_neg;
  logic               w_divisor_neg;
  logic [width_p-1:0] w_dividend_abs;
  logic [width_p-1:0] w_divisor_abs;
  logic [CW-1:0]      w_msb_count;
  logic [CW:0]        w_m_round;
  logic [CW-1:0]      w_iters;
  logic [CW-1:0]      w_shift;
  logic [width_p-1:0] w_dividend_shifted;

  logic [width_p:0]   w_trial;
  logic [width_p-1:0] w_rem_next;
  logic [width_p-1:0] w_quo_next;

  logic [width_p-1:0] w_quotient_fix;
  logic [width_p-1:0] w_remainder_fix;

  // Reset also masks ready so no request can slip in while reset is held.
  assign ready_and_o = (r_state == eIDLE) & ~reset_i;
  assign w_accept    = v_i & ready_and_o;
  assign v_o         = (r_state == eDONE);
  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;

`ifdef BSG_IDIV_ITERATIVE_FAST_RESULT_CACHE_EN
  logic               r_cache_v;
  logic [width_p-1:0] r_cache_dividend;
  logic [width_p-1:0] r_cache_divisor;
  logic               r_cache_signed;
  logic [width_p-1:0] r_cache_quotient;
  logic [width_p-1:0] r_cache_remainder;

  // Single-entry result cache. Written only when a computation reaches the
  // fix-up stage, so a reset-aborted divide never pollutes the entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cache_v         <= 1'b0;
      r_cache_dividend  <= '0;
      r_cache_divisor   <= '0;
      r_cache_signed    <= 1'b0;
      r_cache_quotient  <= '0;
      r_cache_remainder <= '0;
    end else if (r_state == eFIX) begin
      r_cache_v         <= 1'b1;
      r_cache_dividend  <= r_dividend;
      r_cache_divisor   <= r_divisor;
      r_cache_signed    <= r_signed;
      r_cache_quotient  <= w_quotient_fix;
      r_cache_remainder <= w_remainder_fix;
    end
  end

  assign w_cache_hit       = r_cache_v
                           & (dividend_i   == r_cache_dividend)
                           & (divisor_i    == r_cache_divisor)
                           & (signed_div_i == r_cache_signed);
  assign w_cache_quotient  = r_cache_quotient;
  assign w_cache_remainder = r_cache_remainder;
`else
  assign w_cache_hit       = 1'b0;
  assign w_cache_quotient  = '0;
  assign w_cache_remainder = '0;
`endif

  // Operand magnitudes. Signed MIN stays 0x80..0 which is its correct
  // unsigned magnitude, so MIN / -1 needs no special case.
  assign w_dividend_neg = r_signed & r_dividend[width_p-1];
  assign w_divisor_neg  = r_signed & r_divisor[width_p-1];
  assign w_dividend_abs = w_dividend_neg ? -r_dividend : r_dividend;
  assign w_divisor_abs  = w_divisor_neg  ? -r_divisor  : r_divisor;

  // Number of significant bits of |dividend| (width_p - leading zeros).
  always_comb begin
    w_msb_count = '0;
    for (int i = 0; i < width_p; i++) begin
      if (w_dividend_abs[i]) begin
        w_msb_count = CW'(i + 1);
      end
    end
  end

  // Iteration count and pre-shift. The dividend is shifted up so that the
  // N*bits_per_iter_p bits actually iterated sit at the top of the quotient
  // shift register; the skipped high bits become quotient zeros.
  always_comb begin
    w_m_round = {1'b0, w_msb_count} + ROUND_C;
    if ((r_divisor == '0) || (r_dividend == '0)) begin
      w_iters = '0;
    end else if (early_out_p != 0) begin
      w_iters = CW'(w_m_round >> LOG_B);
    end else begin
      w_iters = FULL_ITERS_C;
    end
    w_shift            = WIDTH_C - CW'(w_iters << LOG_B);
    w_dividend_shifted = w_dividend_abs << w_shift;
  end

  // One iteration: bits_per_iter_p chained restoring steps. The trial value
  // is one bit wider than the operands so the shifted remainder never
  // overflows before the compare.
  always_comb begin
    w_rem_next = r_rem;
    w_quo_next = r_quo;
    w_trial    = '0;
    for (int i = 0; i < bits_per_iter_p; i++) begin
      w_trial    = {w_rem_next, w_quo_next[width_p-1]};
      w_quo_next = {w_quo_next[width_p-2:0], 1'b0};
      if (w_trial >= {1'b0, r_divisor_abs}) begin
        w_trial       = w_trial - {1'b0, r_divisor_abs};
        w_quo_next[0] = 1'b1;
      end
      w_rem_next = w_trial[width_p-1:0];
    end
  end

  // Sign fix-up. Divide-by-zero returns all ones and the dividend as given.
  always_comb begin
    if (r_div_zero) begin
      w_quotient_fix  = '1;
      w_remainder_fix = r_dividend;
    end else begin
      w_quotient_fix  = r_neg_q ? -r_quo : r_quo;
      w_remainder_fix = r_neg_r ? -r_rem : r_rem;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A zero iteration count jumps straight to fix-up.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      eIDLE: begin
        if (w_accept) begin
          w_state_next = w_cache_hit ? eDONE : eCALC;
        end
      end
      eCALC: begin
        w_state_next = (w_iters == '0) ? eFIX : eDIV;
      end
      eDIV: begin
        if (r_iter == CW'(1)) begin
          w_state_next = eFIX;
        end
      end
      eFIX: begin
        w_state_next = eDONE;
      end
      eDONE: begin
        if (yumi_i) begin
          w_state_next = eIDLE;
        end
      end
      default: begin
        w_state_next = eIDLE;
      end
    endcase
  end

  // Datapath registers, advanced according to the current state. Results
  // are only written in fix-up (or from the cache on a hit), so they stay
  // stable for the whole time v_o is high.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_signed      <= 1'b0;
      r_divisor_abs <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_iter        <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_div_zero    <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
    end else begin
      case (r_state)
        eIDLE: begin
          if (w_accept) begin
            r_dividend <= dividend_i;
            r_divisor  <= divisor_i;
            r_signed   <= signed_div_i;
            if (w_cache_hit) begin
              r_quotient  <= w_cache_quotient;
              r_remainder <= w_cache_remainder;
            end
          end
        end
        eCALC: begin
          r_divisor_abs <= w_divisor_abs;
          r_rem         <= '0;
          r_quo         <= w_dividend_shifted;
          r_iter        <= w_iters;
          r_neg_q       <= w_dividend_neg ^ w_divisor_neg;
          r_neg_r       <= w_dividend_neg;
          r_div_zero    <= (r_divisor == '0);
        end
        eDIV: begin
          r_rem  <= w_rem_next;
          r_quo  <= w_quo_next;
          r_iter <= r_iter - CW'(1);
        end
        eFIX: begin
          r_quotient  <= w_quotient_fix;
          r_remainder <= w_remainder_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_idiv_iterative_fast.sv
// ---------------------------------------------------------------------------
// tb_bsg_idiv_iterative_fast
//
// Directed bench for bsg_idiv_iterative_fast. The main instance uses the
// default configuration (32 bits, 1 bit per iteration, early out); two more
// instances cover 2 and 4 bits per iteration. Latency is counted in cycles
// after the acceptance cycle (acceptance = cycle 0). Expected results and
// latencies are hand-computed constants. The cache scenario expects a
// one-cycle hit when BSG_IDIV_ITERATIVE_FAST_RESULT_CACHE_EN is defined and
// the full latency otherwise.
// ---------------------------------------------------------------------------
module tb_bsg_idiv_iterative_fast;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i, v2_i, v4_i;
  logic        ready_and_o, ready2_o, ready4_o;
  logic [31:0] dividend_i, divisor_i;
  logic        signed_div_i;
  logic        v_o, v2_o, v4_o;
  logic [31:0] quotient_o, remainder_o, q2_o, r2_o, q4_o, r4_o;
  logic        yumi_i, yumi2_i, yumi4_i;

  int checks = 0;
  int fails  = 0;

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  bsg_idiv_iterative_fast #(.width_p(32), .bits_per_iter_p(1), .early_out_p(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .ready_and_o(ready_and_o),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_div_i(signed_div_i),
    .v_o(v_o), .quotient_o(quotient_o), .remainder_o(remainder_o), .yumi_i(yumi_i));

  bsg_idiv_iterative_fast #(.width_p(32), .bits_per_iter_p(2), .early_out_p(1)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v2_i), .ready_and_o(ready2_o),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_div_i(signed_div_i),
    .v_o(v2_o), .quotient_o(q2_o), .remainder_o(r2_o), .yumi_i(yumi2_i));

  bsg_idiv_iterative_fast #(.width_p(32), .bits_per_iter_p(4), .early_out_p(1)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v4_i), .ready_and_o(ready4_o),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .signed_div_i(signed_div_i),
    .v_o(v4_o), .quotient_o(q4_o), .remainder_o(r4_o), .yumi_i(yumi4_i));

  // Drive one request on the main instance and return the cycle in which
  // v_o is first seen (bounded at 200).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s, output int lat);
    @(negedge clk_i);
    dividend_i   = a;
    divisor_i    = b;
    signed_div_i = s;
    v_i          = 1'b1;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    lat = 1;
    while (v_o !== 1'b1 && lat < 200) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  // Take the current result on the main instance.
  task automatic consumeResult();
    @(negedge clk_i);
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
  endtask

  task automatic doReset(input int n);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Reset values and ready behaviour around deassertion.
  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (ready_and_o !== 1'b0 || ready2_o !== 1'b0 || ready4_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ready_low: got %b%b%b, expected 000", ready_and_o, ready2_o, ready4_o);
    end
    checks++;
    if (v_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_v_o: got %b, expected 0", v_o);
    end
    checks++;
    if (quotient_o !== 32'h0 || remainder_o !== 32'h0) begin
      fails++;
      $display("[TB] FAIL reset_results: got q=%h r=%h, expected 0/0", quotient_o, remainder_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (ready_and_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready_after: got %b, expected 1", ready_and_o);
    end
  endtask

  // Ordinary signed and unsigned divisions.
  task automatic test_divide();
    logic [31:0] ta[6], tb[6], eq[6], er[6];
    logic        ts[6];
    int          el[6];
    int          lat;
    ta = '{32'd100, 32'hFFFFFF9C, 32'd100,      32'd1000, 32'hFFFFFF9C, 32'd7};
    tb = '{32'd7,   32'd7,        32'hFFFFFFF9, 32'd10,   32'd7,        32'd100};
    ts = '{1'b1,    1'b1,         1'b1,         1'b0,     1'b0,         1'b0};
    el = '{10,      10,           10,           13,       35,           6};
    eq = '{32'd14,  32'hFFFFFFF2, 32'hFFFFFFF2, 32'd100,  32'h24924916, 32'd0};
    er = '{32'd2,   32'hFFFFFFFE, 32'd2,        32'd0,    32'd2,        32'd7};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(ta[i], tb[i], ts[i], lat);
      checks++;
      if (lat !== el[i]) begin
        fails++;
        $display("[TB] FAIL divide[%0d] latency: got %0d, expected %0d", i, lat, el[i]);
      end
      checks++;
      if (quotient_o !== eq[i]) begin
        fails++;
        $display("[TB] FAIL divide[%0d] quotient: got %h, expected %h", i, quotient_o, eq[i]);
      end
      checks++;
      if (remainder_o !== er[i]) begin
        fails++;
        $display("[TB] FAIL divide[%0d] remainder: got %h, expected %h", i, remainder_o, er[i]);
      end
      consumeResult();
    end
  endtask

  // Divide by zero, MIN / -1, zero dividend.
  task automatic test_special();
    logic [31:0] ta[5], tb[5], eq[5], er[5];
    logic        ts[5];
    int          el[5];
    int          lat;
    ta = '{32'd5,        32'hFFFFFFFB, 32'h80000000, 32'd0, 32'd0};
    tb = '{32'd0,        32'd0,        32'hFFFFFFFF, 32'd7, 32'd0};
    ts = '{1'b0,         1'b1,         1'b1,         1'b1,  1'b0};
    el = '{3,            3,            35,           3,     3};
    eq = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    er = '{32'd5,        32'hFFFFFFFB, 32'd0,        32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ta[i], tb[i], ts[i], lat);
      checks++;
      if (lat !== el[i]) begin
        fails++;
        $display("[TB] FAIL special[%0d] latency: got %0d, expected %0d", i, lat, el[i]);
      end
      checks++;
      if (quotient_o !== eq[i]) begin
        fails++;
        $display("[TB] FAIL special[%0d] quotient: got %h, expected %h", i, quotient_o, eq[i]);
      end
      checks++;
      if (remainder_o !== er[i]) begin
        fails++;
        $display("[TB] FAIL special[%0d] remainder: got %h, expected %h", i, remainder_o, er[i]);
      end
      consumeResult();
    end
  endtask

  // 2 and 4 bits per iteration, run side by side on the same operands.
  task automatic test_radix();
    logic [31:0] ta[2], tb[2], eq[2], er[2];
    logic        ts[2];
    int          el2[2], el4[2];
    int          lat, l2, l4;
    logic [31:0] cq2, cr2, cq4, cr4;
    ta  = '{32'hFFFFFFFF, 32'hFFFFFF9C};
    tb  = '{32'd1,        32'd7};
    ts  = '{1'b0,         1'b1};
    el2 = '{19,           7};
    el4 = '{11,           5};
    eq  = '{32'hFFFFFFFF, 32'hFFFFFFF2};
    er  = '{32'd0,        32'hFFFFFFFE};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      dividend_i   = ta[i];
      divisor_i    = tb[i];
      signed_div_i = ts[i];
      v2_i         = 1'b1;
      v4_i         = 1'b1;
      @(posedge clk_i);
      #1;
      v2_i = 1'b0;
      v4_i = 1'b0;
      lat = 1; l2 = 0; l4 = 0;
      cq2 = '0; cr2 = '0; cq4 = '0; cr4 = '0;
      while (lat < 200 && (l2 == 0 || l4 == 0)) begin
        if (l2 == 0 && v2_o === 1'b1) begin
          l2 = lat; cq2 = q2_o; cr2 = r2_o;
        end
        if (l4 == 0 && v4_o === 1'b1) begin
          l4 = lat; cq4 = q4_o; cr4 = r4_o;
        end
        if (l2 == 0 || l4 == 0) begin
          @(posedge clk_i);
          #1;
          lat++;
        end
      end
      checks++;
      if (l2 !== el2[i]) begin
        fails++;
        $display("[TB] FAIL radix2[%0d] latency: got %0d, expected %0d", i, l2, el2[i]);
      end
      checks++;
      if (l4 !== el4[i]) begin
        fails++;
        $display("[TB] FAIL radix4[%0d] latency: got %0d, expected %0d", i, l4, el4[i]);
      end
      checks++;
      if (cq2 !== eq[i] || cr2 !== er[i]) begin
        fails++;
        $display("[TB] FAIL radix2[%0d] result: got q=%h r=%h, expected q=%h r=%h", i, cq2, cr2, eq[i], er[i]);
      end
      checks++;
      if (cq4 !== eq[i] || cr4 !== er[i]) begin
        fails++;
        $display("[TB] FAIL radix4[%0d] result: got q=%h r=%h, expected q=%h r=%h", i, cq4, cr4, eq[i], er[i]);
      end
      @(negedge clk_i);
      yumi2_i = 1'b1;
      yumi4_i = 1'b1;
      @(posedge clk_i);
      #1;
      yumi2_i = 1'b0;
      yumi4_i = 1'b0;
    end
  endtask

  // Hold the result for 5 cycles; a v_i pulse in that window is ignored.
  task automatic test_backpressure();
    int lat;
    applyStimulus(32'd77, 32'd5, 1'b0, lat);
    checks++;
    if (lat !== 10 || quotient_o !== 32'd15 || remainder_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL bp_first: got lat=%0d q=%h r=%h, expected lat=10 q=f r=2", lat, quotient_o, remainder_o);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        @(negedge clk_i);
        dividend_i   = 32'd9;
        divisor_i    = 32'd3;
        signed_div_i = 1'b0;
        v_i          = 1'b1;
      end
      @(posedge clk_i);
      #1;
      v_i = 1'b0;
      checks++;
      if (v_o !== 1'b1 || ready_and_o !== 1'b0 || quotient_o !== 32'd15 || remainder_o !== 32'd2) begin
        fails++;
        $display("[TB] FAIL bp_hold[%0d]: got v_o=%b ready=%b q=%h r=%h, expected 1 0 f 2", k, v_o, ready_and_o, quotient_o, remainder_o);
      end
    end
    consumeResult();
    checks++;
    if (v_o !== 1'b0 || ready_and_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_release: got v_o=%b ready=%b, expected 0 1", v_o, ready_and_o);
    end
    applyStimulus(32'd9, 32'd3, 1'b0, lat);
    checks++;
    if (lat !== 7 || quotient_o !== 32'd3 || remainder_o !== 32'd0) begin
      fails++;
      $display("[TB] FAIL bp_next: got lat=%0d q=%h r=%h, expected lat=7 q=3 r=0", lat, quotient_o, remainder_o);
    end
    consumeResult();
  endtask

  // Reset in cycle 4 of a 35-cycle divide aborts it silently.
  task automatic test_reset_mid_op();
    int   lat;
    logic sawV;
    @(negedge clk_i);
    dividend_i   = 32'h80000000;
    divisor_i    = 32'hFFFFFFFF;
    signed_div_i = 1'b1;
    v_i          = 1'b1;
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (ready_and_o !== 1'b0 || v_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_during: got ready=%b v_o=%b, expected 0 0", ready_and_o, v_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (ready_and_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL midreset_ready: got %b, expected 1", ready_and_o);
    end
    sawV = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (v_o !== 1'b0) sawV = 1'b1;
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (sawV !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_no_v_o: got v_o seen=%b, expected 0", sawV);
    end
    applyStimulus(32'd100, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 10 || quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL midreset_fresh: got lat=%0d q=%h r=%h, expected lat=10 q=e r=2", lat, quotient_o, remainder_o);
    end
    consumeResult();
  endtask

  // Same request twice back to back, then again after a reset.
  task automatic test_back_to_back();
    int lat;
    int hitLat;
`ifdef BSG_IDIV_ITERATIVE_FAST_RESULT_CACHE_EN
    hitLat = 1;
`else
    hitLat = 10;
`endif
    doReset(2);
    applyStimulus(32'd100, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 10 || quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL b2b_first: got lat=%0d q=%h r=%h, expected lat=10 q=e r=2", lat, quotient_o, remainder_o);
    end
    consumeResult();
    applyStimulus(32'd100, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== hitLat) begin
      fails++;
      $display("[TB] FAIL b2b_second latency: got %0d, expected %0d", lat, hitLat);
    end
    checks++;
    if (quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL b2b_second result: got q=%h r=%h, expected q=e r=2", quotient_o, remainder_o);
    end
    consumeResult();
    doReset(2);
    applyStimulus(32'd100, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 10 || quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
      fails++;
      $display("[TB] FAIL b2b_after_reset: got lat=%0d q=%h r=%h, expected lat=10 q=e r=2", lat, quotient_o, remainder_o);
    end
    consumeResult();
  endtask

  initial begin
    reset_i      = 1'b1;
    v_i          = 1'b0;
    v2_i         = 1'b0;
    v4_i         = 1'b0;
    yumi_i       = 1'b0;
    yumi2_i      = 1'b0;
    yumi4_i      = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    signed_div_i = 1'b0;
    test_reset();
    test_divide();
    test_special();
    test_radix();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
